regfile_wr_arbiter: RTL and testbench

Controller for the shared register-file write port. It arbitrates the single write port between the in-order pipeline writeback (port A) and the multi-cycle unit return path (port B, loads and multiplies) and drives the registered write enables into the register file. It also keeps a 32-entry busy scoreboard for hazard detection and stalls the pipeline when port B is starved. It sits between MEM/WB and the register file, replacing direct drive of the write decoder.

---
 rtl/regfile_wr_arbiter_pkg.sv | 13 +
 rtl/regfile_wr_arbiter_dec.sv | 15 +
 rtl/regfile_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam logic [4:0]  REG_XZR        = 5'd31;
  localparam int unsigned DEFAULT_DATA_W = 64;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_dec.sv
// Combinational 5-to-32 one-hot decoder with enable; registered by the arbiter.
module wr_onehot_dec
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [4:0]          idx,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (A)
// and the multi-cycle return path (B); keeps a busy scoreboard and a starvation stall.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                a_valid,
  input  logic [4:0]          a_reg,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [4:0]          b_reg,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                rsv_valid,
  input  logic [4:0]          rsv_reg,
  output logic                wr_en,
  output logic [4:0]          wr_reg,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] rf_we,
  output logic [NUM_REGS-1:0] busy,
  output logic                stall_pipe,
  output logic                proto_err
);

  logic                acc_b;
  logic                b_waiting;
  logic                launch_vld;
  logic                launch_en;
  logic [4:0]          launch_reg;
  logic [DATA_W-1:0]   launch_data;
  logic [NUM_REGS-1:0] dec_onehot;
  logic [NUM_REGS-1:0] busy_next;
  logic [3:0]          starve_cnt;
  logic [3:0]          cnt_inc;
  wr_state_t           state;

  assign b_ready   = !a_valid;
  assign acc_b     = b_valid && !a_valid;
  assign b_waiting = b_valid && a_valid;

  always_comb begin
    launch_vld  = 1'b0;
    launch_reg  = '0;
    launch_data = '0;
    if (a_valid) begin
      launch_vld  = 1'b1;
      launch_reg  = a_reg;
      launch_data = a_data;
    end else if (b_valid) begin
      launch_vld  = 1'b1;
      launch_reg  = b_reg;
      launch_data = b_data;
    end
    // XZR writes are accepted but never strobe the register file
    launch_en = launch_vld && (launch_reg != REG_XZR);
  end

  wr_onehot_dec u_dec (
    .en     (launch_en),
    .idx    (launch_reg),
    .onehot (dec_onehot)
  );

  // Clear from B acceptance first, so a same-cycle reservation wins
  always_comb begin
    busy_next = busy;
    if (acc_b) busy_next[b_reg] = 1'b0;
    if (rsv_valid && (rsv_reg != REG_XZR)) busy_next[rsv_reg] = 1'b1;
  end

  assign cnt_inc = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
      rf_we   <= '0;
      busy    <= '0;
    end else begin
      wr_en <= launch_en;
      rf_we <= dec_onehot;
      busy  <= busy_next;
      if (launch_vld) begin
        wr_reg  <= launch_reg;
        wr_data <= launch_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      state      <= NORMAL;
      stall_pipe <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      starve_cnt <= b_waiting ? cnt_inc : 4'd0;
      case (state)
        NORMAL: begin
          if (b_waiting && (cnt_inc == 4'(STARVE_LIMIT))) begin
            state      <= DRAIN;
            stall_pipe <= 1'b1;
          end
        end
        DRAIN: begin
          if (a_valid) proto_err <= 1'b1;
          if (acc_b || !b_valid) begin
            state      <= NORMAL;
            stall_pipe <= 1'b0;
          end
        end
        default: begin
          state      <= NORMAL;
          stall_pipe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_regfile_wr_arbiter;

  localparam int DW    = 64;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_valid;
  logic [4:0]    a_reg;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_reg;
  logic [DW-1:0] b_data;
  logic          rsv_valid;
  logic [4:0]    rsv_reg;
  logic          wr_en;
  logic [4:0]    wr_reg;
  logic [DW-1:0] wr_data;
  logic [31:0]   rf_we;
  logic [31:0]   busy;
  logic          stall_pipe;
  logic          proto_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference model state
  bit          m_wr_en;
  bit [4:0]    m_wr_reg;
  bit [DW-1:0] m_wr_data;
  bit [31:0]   m_busy;
  int          m_wait;
  bit          m_drain;
  bit          m_err;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a_valid    (a_valid),
    .a_reg      (a_reg),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_reg      (b_reg),
    .b_data     (b_data),
    .rsv_valid  (rsv_valid),
    .rsv_reg    (rsv_reg),
    .wr_en      (wr_en),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .rf_we      (rf_we),
    .busy       (busy),
    .stall_pipe (stall_pipe),
    .proto_err  (proto_err)
  );

  function automatic bit [31:0] exp_rf_we();
    return m_wr_en ? (32'd1 << m_wr_reg) : 32'd0;
  endfunction

  task automatic idle();
    a_valid = 0; a_reg = '0; a_data = '0;
    b_valid = 0; b_reg = '0; b_data = '0;
    rsv_valid = 0; rsv_reg = '0;
  endtask

  task automatic model_reset();
    m_wr_en = 0; m_wr_reg = '0; m_wr_data = '0; m_busy = '0;
    m_wait = 0; m_drain = 0; m_err = 0;
  endtask

  // Advance one clock and move the model forward from the inputs held this cycle.
  task automatic step();
    bit          acc;
    bit [4:0]    r;
    bit [DW-1:0] d;
    bit [31:0]   nb;
    int          nw;
    bit          nd;
    bit          ne;
    acc = 0; r = '0; d = '0;
    if (a_valid) begin acc = 1; r = a_reg; d = a_data; end
    else if (b_valid) begin acc = 1; r = b_reg; d = b_data; end
    nb = m_busy;
    if (b_valid && !a_valid) nb[b_reg] = 1'b0;
    if (rsv_valid && rsv_reg != 5'd31) nb[rsv_reg] = 1'b1;
    nw = (a_valid && b_valid) ? ((m_wait + 1 > 15) ? 15 : m_wait + 1) : 0;
    ne = m_err || (m_drain && a_valid);
    if (!m_drain) nd = a_valid && b_valid && (nw == LIMIT);
    else          nd = a_valid && b_valid;
    @(posedge clk);
    #1;
    m_wr_en = acc && (r != 5'd31);
    if (acc) begin m_wr_reg = r; m_wr_data = d; end
    m_busy = nb; m_wait = nw; m_drain = nd; m_err = ne;
  endtask

  task automatic apply_reset();
    reset_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    #3;
    a_valid = 1;
    #1;
    n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL reset_b_ready got=%b want=0", b_ready); end
    a_valid = 0;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_ready_idle got=%b want=1", b_ready); end
    apply_reset();
    n_cmp++;
    if ({wr_en, stall_pipe, proto_err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl got wr_en=%b stall=%b err=%b want 0", wr_en, stall_pipe, proto_err);
    end
    n_cmp++; if (rf_we !== 32'd0) begin n_bad++; $display("FAIL reset_rf_we got=%h want=0", rf_we); end
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("FAIL reset_busy got=%h want=0", busy); end
    n_cmp++;
    if (wr_reg !== 5'd0 || wr_data !== '0) begin
      n_bad++; $display("FAIL reset_wr got reg=%0d data=%h want 0", wr_reg, wr_data);
    end
  endtask

  task automatic test_a_write();
    a_valid = 1; a_reg = 5'd5; a_data = 64'hAA;
    step();
    idle();
    n_cmp++;
    if (wr_en !== 1'b1 || wr_reg !== 5'd5 || wr_data !== 64'hAA) begin
      n_bad++; $display("FAIL a_write got en=%b reg=%0d data=%h want 1/5/aa", wr_en, wr_reg, wr_data);
    end
    n_cmp++; if (rf_we !== 32'h20) begin n_bad++; $display("FAIL a_write_rf_we got=%h want=00000020", rf_we); end
    step();
    n_cmp++; if (wr_en !== 1'b0 || rf_we !== 32'd0) begin n_bad++; $display("FAIL a_idle got en=%b rf_we=%h want 0", wr_en, rf_we); end
  endtask

  task automatic test_priority();
    a_valid = 1; a_reg = 5'd3; a_data = 64'h33;
    b_valid = 1; b_reg = 5'd7; b_data = 64'hBB;
    #1;
    n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL prio_b_ready got=%b want=0", b_ready); end
    step();
    n_cmp++;
    if (wr_reg !== 5'd3 || rf_we !== 32'h8 || wr_data !== 64'h33) begin
      n_bad++; $display("FAIL prio_a got reg=%0d rf_we=%h data=%h want 3/00000008/33", wr_reg, rf_we, wr_data);
    end
    a_valid = 0;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL prio_b_ready_free got=%b want=1", b_ready); end
    step();
    idle();
    n_cmp++;
    if (wr_reg !== 5'd7 || rf_we !== 32'h80 || wr_data !== 64'hBB) begin
      n_bad++; $display("FAIL prio_b got reg=%0d rf_we=%h data=%h want 7/00000080/bb", wr_reg, rf_we, wr_data);
    end
    step();
  endtask

  task automatic test_starve_release();
    a_valid = 1; a_reg = 5'd2; a_data = 64'h1;
    b_valid = 1; b_reg = 5'd12; b_data = 64'hC0DE;
    for (int i = 1; i <= LIMIT; i++) begin
      step();
      n_cmp++;
      if (stall_pipe !== (i == LIMIT)) begin
        n_bad++; $display("FAIL starve_edge%0d got stall=%b want=%b", i, stall_pipe, (i == LIMIT));
      end
    end
    a_valid = 0;
    step();
    idle();
    n_cmp++;
    if (stall_pipe !== 1'b0 || proto_err !== 1'b0) begin
      n_bad++; $display("FAIL starve_release got stall=%b err=%b want 0/0", stall_pipe, proto_err);
    end
    n_cmp++;
    if (wr_en !== 1'b1 || wr_reg !== 5'd12 || wr_data !== 64'hC0DE) begin
      n_bad++; $display("FAIL starve_b_write got en=%b reg=%0d data=%h want 1/12/c0de", wr_en, wr_reg, wr_data);
    end
    step();
  endtask

  task automatic test_starve_proto_err();
    a_valid = 1; a_reg = 5'd6; a_data = 64'h66;
    b_valid = 1; b_reg = 5'd13; b_data = 64'hDD;
    repeat (LIMIT) step();
    a_reg = 5'd10; a_data = 64'h1010;
    step();
    n_cmp++;
    if (proto_err !== 1'b1 || stall_pipe !== 1'b1) begin
      n_bad++; $display("FAIL proto_err_set got err=%b stall=%b want 1/1", proto_err, stall_pipe);
    end
    n_cmp++; if (wr_reg !== 5'd10 || wr_data !== 64'h1010) begin n_bad++; $display("FAIL proto_a_served got reg=%0d want=10", wr_reg); end
    a_valid = 0;
    step();
    idle();
    n_cmp++;
    if (proto_err !== 1'b1 || stall_pipe !== 1'b0 || wr_reg !== 5'd13) begin
      n_bad++; $display("FAIL proto_sticky got err=%b stall=%b reg=%0d want 1/0/13", proto_err, stall_pipe, wr_reg);
    end
    apply_reset();
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL proto_cleared got=%b want=0", proto_err); end
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1; rsv_reg = 5'd9;
    step();
    idle();
    n_cmp++; if (busy !== 32'h200) begin n_bad++; $display("FAIL sb_set got=%h want=00000200", busy); end
    a_valid = 1; a_reg = 5'd9; a_data = 64'h9;
    step();
    idle();
    n_cmp++; if (busy !== 32'h200) begin n_bad++; $display("FAIL sb_a_untouched got=%h want=00000200", busy); end
    b_valid = 1; b_reg = 5'd9; b_data = 64'h99;
    step();
    idle();
    n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL sb_clear got=%h want=0", busy); end
    rsv_valid = 1; rsv_reg = 5'd9;
    b_valid = 1; b_reg = 5'd9; b_data = 64'h98;
    step();
    idle();
    n_cmp++; if (busy !== 32'h200) begin n_bad++; $display("FAIL sb_set_wins got=%h want=00000200", busy); end
    b_valid = 1; b_reg = 5'd9;
    step();
    idle();
    n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL sb_reclear got=%h want=0", busy); end
  endtask

  task automatic test_xzr();
    a_valid = 1; a_reg = 5'd31; a_data = 64'hF1;
    step();
    idle();
    n_cmp++; if (wr_en !== 1'b0 || rf_we !== 32'd0) begin n_bad++; $display("FAIL xzr_a got en=%b rf_we=%h want 0", wr_en, rf_we); end
    b_valid = 1; b_reg = 5'd31; b_data = 64'hF2;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL xzr_b_ready got=%b want=1", b_ready); end
    step();
    idle();
    n_cmp++; if (wr_en !== 1'b0 || rf_we !== 32'd0) begin n_bad++; $display("FAIL xzr_b got en=%b rf_we=%h want 0", wr_en, rf_we); end
    rsv_valid = 1; rsv_reg = 5'd31;
    step();
    idle();
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("FAIL xzr_rsv got=%h want=0", busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_valid   = ($urandom_range(0, 99) < 55);
      a_reg     = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom);
      a_data    = {$urandom, $urandom};
      b_valid   = ($urandom_range(0, 99) < 65);
      b_reg     = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom);
      b_data    = {$urandom, $urandom};
      rsv_valid = ($urandom_range(0, 99) < 30);
      rsv_reg   = 5'($urandom);
      #1;
      n_cmp++; if (b_ready !== !a_valid) begin n_bad++; $display("FAIL rnd%0d b_ready got=%b want=%b", i, b_ready, !a_valid); end
      step();
      n_cmp++;
      if (wr_en !== m_wr_en || rf_we !== exp_rf_we()) begin
        n_bad++; $display("FAIL rnd%0d wr got en=%b rf_we=%h want %b/%h", i, wr_en, rf_we, m_wr_en, exp_rf_we());
      end
      if (m_wr_en) begin
        n_cmp++;
        if (wr_reg !== m_wr_reg || wr_data !== m_wr_data) begin
          n_bad++; $display("FAIL rnd%0d wr_addr got reg=%0d data=%h want %0d/%h", i, wr_reg, wr_data, m_wr_reg, m_wr_data);
        end
      end
      n_cmp++;
      if (busy !== m_busy || stall_pipe !== m_drain || proto_err !== m_err) begin
        n_bad++; $display("FAIL rnd%0d state got busy=%h stall=%b err=%b want %h/%b/%b",
                          i, busy, stall_pipe, proto_err, m_busy, m_drain, m_err);
      end
    end
    idle();
    apply_reset();
  endtask

  task automatic test_reset_in_drain();
    rsv_valid = 1; rsv_reg = 5'd8;
    step();
    rsv_reg = 5'd9;
    step();
    idle();
    n_cmp++; if (busy !== 32'h300) begin n_bad++; $display("FAIL drain_busy_setup got=%h want=00000300", busy); end
    a_valid = 1; a_reg = 5'd4; a_data = 64'h44;
    b_valid = 1; b_reg = 5'd20; b_data = 64'h20;
    repeat (LIMIT) step();
    n_cmp++;
    if (stall_pipe !== 1'b1 || wr_en !== 1'b1) begin
      n_bad++; $display("FAIL drain_setup got stall=%b en=%b want 1/1", stall_pipe, wr_en);
    end
    #2;
    reset_n = 0;
    #1;
    n_cmp++;
    if (stall_pipe !== 1'b0 || busy !== 32'd0 || wr_en !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got stall=%b busy=%h en=%b want 0/0/0", stall_pipe, busy, wr_en);
    end
    apply_reset();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_a_write();
    test_priority();
    test_starve_release();
    test_starve_proto_err();
    test_scoreboard();
    test_xzr();
    test_random();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
